// File: rtl/matmul_sp_writeback.sv
// Captures a finished C matrix and streams it row by row into the scratchpad write port.
// Define SP_WB_FLAGS_STICKY_EN to make flags_o accumulate across captures until clr_flags_i.
module matmul_sp_writeback #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 16,
  parameter int SP_NTARGETS = 4,
  parameter int ADDR_WIDTH  = 3,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int EW         = 2 * DATA_WIDTH,
  localparam int MAT_W      = MAX_DIM * MAX_DIM * EW,
  localparam int ROW_W      = MAX_DIM * EW,
  localparam int NFLAGS     = MAX_DIM * MAX_DIM,
  localparam int TGT_W      = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_w_i,
  input  logic [MAT_W-1:0]      c_matrix_i,
  input  logic [NFLAGS-1:0]     flags_i,
  input  logic [2:0]            n_dim_i,
  input  logic [2:0]            m_dim_i,
  input  logic [TGT_W-1:0]      sp_target_i,
  input  logic                  sp_ready_i,
  input  logic                  clr_flags_i,
  output logic                  sp_we_o,
  output logic [ADDR_WIDTH-1:0] sp_addr_o,
  output logic [ROW_W-1:0]      sp_wdata_o,
  output logic [NFLAGS-1:0]     flags_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o
);

  localparam logic [2:0] MAX_DIM3 = 3'(MAX_DIM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [MAT_W-1:0] mat_reg;
  logic [2:0]       n_reg;
  logic [2:0]       m_reg;
  logic [TGT_W-1:0] tgt_reg;
  logic [2:0]       row_reg;
  logic [2:0]       row_next;
  logic [2:0]       n_clamp;
  logic [2:0]       m_clamp;
  logic             capture;

  assign n_clamp  = (n_dim_i > MAX_DIM3) ? MAX_DIM3 : n_dim_i;
  assign m_clamp  = (m_dim_i > MAX_DIM3) ? MAX_DIM3 : m_dim_i;
  assign capture  = enable_w_i && (state_reg == ST_IDLE);
  assign row_next = row_reg + 3'd1;

`ifndef SP_WB_FLAGS_STICKY_EN
  logic unused_clr_flags;
  assign unused_clr_flags = clr_flags_i;
`endif

  function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [TGT_W-1:0] tgt,
                                                     input logic [2:0] row);
    int unsigned a;
    a = 32'(tgt) * MAX_DIM + 32'(row);
    return a[ADDR_WIDTH-1:0];
  endfunction

  // Columns at or beyond m are zeroed so stale matrix contents never reach the scratchpad.
  function automatic logic [ROW_W-1:0] row_data(input logic [MAT_W-1:0] mat,
                                                input logic [2:0] row,
                                                input logic [2:0] m);
    logic [ROW_W-1:0] r;
    int idx;
    r = '0;
    for (int j = 0; j < MAX_DIM; j++) begin
      idx = int'(row) * MAX_DIM + j;
      if ((j < int'(m)) && (idx < NFLAGS)) r[j*EW +: EW] = mat[idx*EW +: EW];
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= ST_IDLE;
      mat_reg    <= '0;
      n_reg      <= '0;
      m_reg      <= '0;
      tgt_reg    <= '0;
      row_reg    <= '0;
      sp_we_o    <= 1'b0;
      sp_addr_o  <= '0;
      sp_wdata_o <= '0;
      flags_o    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= enable_w_i && (state_reg != ST_IDLE);
      done_o    <= 1'b0;

`ifdef SP_WB_FLAGS_STICKY_EN
      // Clear takes effect before the new flags are merged in.
      if (capture)          flags_o <= (clr_flags_i ? '0 : flags_o) | flags_i;
      else if (clr_flags_i) flags_o <= '0;
`else
      if (capture)          flags_o <= flags_i;
`endif

      case (state_reg)
        ST_IDLE: begin
          if (capture) begin
            mat_reg <= c_matrix_i;
            n_reg   <= n_clamp;
            m_reg   <= m_clamp;
            tgt_reg <= sp_target_i;
            row_reg <= '0;
            if (n_clamp == 3'd0) begin
              state_reg <= ST_DONE;
              done_o    <= 1'b1;
            end else begin
              state_reg  <= ST_WRITE;
              sp_we_o    <= 1'b1;
              busy_o     <= 1'b1;
              sp_addr_o  <= row_addr(sp_target_i, 3'd0);
              sp_wdata_o <= row_data(c_matrix_i, 3'd0, m_clamp);
            end
          end
        end
        ST_WRITE: begin
          if (sp_ready_i) begin
            row_reg <= row_next;
            if (row_reg == n_reg - 3'd1) begin
              state_reg  <= ST_DONE;
              sp_we_o    <= 1'b0;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              sp_addr_o  <= '0;
              sp_wdata_o <= '0;
            end else begin
              sp_addr_o  <= row_addr(tgt_reg, row_next);
              sp_wdata_o <= row_data(mat_reg, row_next, m_reg);
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sp_writeback.sv
// Directed self-checking bench for matmul_sp_writeback (default parameters, MAX_DIM = 2).
module tb_matmul_sp_writeback;

  logic        clk_i;
  logic        rst_ni;
  logic        enable_w_i;
  logic [63:0] c_matrix_i;
  logic [3:0]  flags_i;
  logic [2:0]  n_dim_i;
  logic [2:0]  m_dim_i;
  logic [1:0]  sp_target_i;
  logic        sp_ready_i;
  logic        clr_flags_i;
  logic        sp_we_o;
  logic [2:0]  sp_addr_o;
  logic [31:0] sp_wdata_o;
  logic [3:0]  flags_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  int checks;
  int failures;

  matmul_sp_writeback dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_w_i (enable_w_i),
    .c_matrix_i (c_matrix_i),
    .flags_i    (flags_i),
    .n_dim_i    (n_dim_i),
    .m_dim_i    (m_dim_i),
    .sp_target_i(sp_target_i),
    .sp_ready_i (sp_ready_i),
    .clr_flags_i(clr_flags_i),
    .sp_we_o    (sp_we_o),
    .sp_addr_o  (sp_addr_o),
    .sp_wdata_o (sp_wdata_o),
    .flags_o    (flags_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overrun_o  (overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_row(input string tag, input logic [2:0] addr, input logic [31:0] data);
    chk({tag, "_we"}, 64'(sp_we_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    chk({tag, "_addr"}, 64'(sp_addr_o), 64'(addr));
    chk({tag, "_data"}, 64'(sp_wdata_o), 64'(data));
    $display("row %s: addr=%0d data=%h", tag, sp_addr_o, sp_wdata_o);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    chk({tag, "_we_off"}, 64'(sp_we_o), 64'd0);
    chk({tag, "_busy_off"}, 64'(busy_o), 64'd0);
    $display("done %s", tag);
  endtask

  task automatic launch(input logic [63:0] mat, input logic [3:0] fl, input logic [2:0] n,
                        input logic [2:0] m, input logic [1:0] tgt);
    c_matrix_i  = mat;
    flags_i     = fl;
    n_dim_i     = n;
    m_dim_i     = m;
    sp_target_i = tgt;
    enable_w_i  = 1'b1;
    tick();
    enable_w_i  = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_ni      = 1'b0;
    enable_w_i  = 1'b0;
    c_matrix_i  = '0;
    flags_i     = '0;
    n_dim_i     = '0;
    m_dim_i     = '0;
    sp_target_i = '0;
    sp_ready_i  = 1'b1;
    clr_flags_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Reset state
    chk("rst_we", 64'(sp_we_o), 64'd0);
    chk("rst_addr", 64'(sp_addr_o), 64'd0);
    chk("rst_data", 64'(sp_wdata_o), 64'd0);
    chk("rst_flags", 64'(flags_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ovr", 64'(overrun_o), 64'd0);
    $display("reset state checked");

    // 1: basic two-row write into slot 1
    launch(64'h0004_0003_0002_0001, 4'b0001, 3'd2, 3'd2, 2'd1);
    chk_row("t1_r0", 3'd2, 32'h0002_0001);
    chk("t1_flags", 64'(flags_o), 64'h1);
    tick();
    chk_row("t1_r1", 3'd3, 32'h0004_0003);
    tick();
    chk_done("t1");
    tick();
    chk("t1_done_pulse", 64'(done_o), 64'd0);

    // 2: column masking (m=1) into slot 0, second flag capture
    launch(64'h0004_0003_0002_0001, 4'b0100, 3'd2, 3'd1, 2'd0);
    chk_row("t2_r0", 3'd0, 32'h0000_0001);
`ifdef SP_WB_FLAGS_STICKY_EN
    chk("t2_flags", 64'(flags_o), 64'h5);
`else
    chk("t2_flags", 64'(flags_o), 64'h4);
`endif
    tick();
    chk_row("t2_r1", 3'd1, 32'h0000_0003);
    tick();
    chk_done("t2");
    tick();

    // 6: flag clear
    clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
`ifdef SP_WB_FLAGS_STICKY_EN
    chk("t6_clr_flags", 64'(flags_o), 64'h0);
`else
    chk("t6_clr_flags", 64'(flags_o), 64'h4);
`endif
    $display("flags after clear: %b", flags_o);

    // 3: backpressure, ready low for three cycles after first request
    launch(64'h0004_0003_0002_0001, 4'b0000, 3'd2, 3'd2, 2'd1);
    sp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sp_ready_i = 1'b1;
      chk_row("t3_hold", 3'd2, 32'h0002_0001);
      if (i < 3) tick();
    end
    tick();
    chk_row("t3_r1", 3'd3, 32'h0004_0003);
    tick();
    chk_done("t3");
    tick();

    // 4a: overrun during WRITE and at the DONE->IDLE cycle
    launch(64'h0004_0003_0002_0001, 4'b0000, 3'd2, 3'd2, 2'd1);
    chk("t4_ovr_idle", 64'(overrun_o), 64'd0);
    c_matrix_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    sp_target_i = 2'd3;
    n_dim_i     = 3'd1;
    enable_w_i  = 1'b1;
    tick();
    enable_w_i = 1'b0;
    chk("t4_ovr_pulse", 64'(overrun_o), 64'd1);
    chk_row("t4_r1", 3'd3, 32'h0004_0003);
    tick();
    chk_done("t4");
    chk("t4_ovr_clear", 64'(overrun_o), 64'd0);
    enable_w_i = 1'b1;
    tick();
    enable_w_i = 1'b0;
    chk("t4_ovr_done", 64'(overrun_o), 64'd1);
    chk("t4_no_capture", 64'(sp_we_o), 64'd0);
    chk("t4_no_done", 64'(done_o), 64'd0);
    tick();
    chk("t4_idle_we", 64'(sp_we_o), 64'd0);

    // 4b: zero rows
    launch(64'h0004_0003_0002_0001, 4'b0000, 3'd0, 3'd2, 2'd2);
    chk_done("t4_n0");
    tick();
    chk("t4_n0_pulse", 64'(done_o), 64'd0);

    // Clamping n=5, m=7 to 2 and sign bits passed verbatim, slot 2
    launch(64'h8001_FFFF_7FFE_8000, 4'b0000, 3'd5, 3'd7, 2'd2);
    chk_row("clamp_r0", 3'd4, 32'h7FFE_8000);
    tick();
    chk_row("clamp_r1", 3'd5, 32'h8001_FFFF);
    tick();
    chk_done("clamp");
    tick();

    // 5: reset mid-transfer with ready low
    launch(64'h0004_0003_0002_0001, 4'b1111, 3'd2, 3'd2, 2'd1);
    sp_ready_i = 1'b0;
    chk_row("t5_r0", 3'd2, 32'h0002_0001);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_we", 64'(sp_we_o), 64'd0);
    chk("t5_rst_busy", 64'(busy_o), 64'd0);
    chk("t5_rst_addr", 64'(sp_addr_o), 64'd0);
    chk("t5_rst_data", 64'(sp_wdata_o), 64'd0);
    chk("t5_rst_flags", 64'(flags_o), 64'd0);
    $display("async reset mid-transfer checked");
    tick();
    rst_ni     = 1'b1;
    sp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_post_we", 64'(sp_we_o), 64'd0);
      chk("t5_post_done", 64'(done_o), 64'd0);
    end
    $display("post-reset idle checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
